// File: rtl/addr_shift_queue.sv
// In-order shift queue with occupancy flags, simultaneous push/pop, flush and associative lookup.
// Define ADDR_QUEUE_OVERWRITE_EN to make a push on a full queue drop the head instead of being discarded.
module addr_shift_queue #(
    parameter int DATA_BITS = 32,
    parameter int REG_DEPTH = 5,
    parameter int CNT_BITS  = $clog2(REG_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           pushEn,
    input  logic [DATA_BITS-1:0]           inVector,
    input  logic                           popEn,
    input  logic [DATA_BITS-1:0]           lookupAddr,
    output logic [DATA_BITS-1:0]           headData,
    output logic [DATA_BITS*REG_DEPTH-1:0] dataVec,
    output logic [REG_DEPTH-1:0]           validVec,
    output logic [CNT_BITS-1:0]            count,
    output logic                           full,
    output logic                           empty,
    output logic                           overflow,
    output logic                           underflow,
    output logic                           lookupHit,
    output logic [$clog2(REG_DEPTH)-1:0]   lookupIdx
);
    localparam int                  IDX_BITS = $clog2(REG_DEPTH);
    localparam logic [CNT_BITS-1:0] DEPTH_C  = CNT_BITS'(REG_DEPTH);

    logic [DATA_BITS-1:0] r_data [REG_DEPTH];
    logic [CNT_BITS-1:0]  r_count;
    logic [REG_DEPTH-1:0] r_valid;
    logic                 r_full;
    logic                 r_empty;
    logic                 r_overflow;
    logic                 r_underflow;

    logic                 w_shift;
    logic                 w_write;
    logic [IDX_BITS-1:0]  w_widx;
    logic [CNT_BITS-1:0]  w_count_nxt;
    logic [DATA_BITS-1:0] w_data_nxt [REG_DEPTH];
    logic [REG_DEPTH-1:0] w_valid_nxt;
    logic                 w_ovf;
    logic                 w_unf;
    logic                 w_hit;
    logic [IDX_BITS-1:0]  w_hit_idx;

    // Every accepted operation reduces to: optional shift-down, then optional write at w_widx.
    always_comb begin
        w_shift     = 1'b0;
        w_write     = 1'b0;
        w_widx      = '0;
        w_count_nxt = r_count;
        w_ovf       = pushEn && !popEn && r_full;
        w_unf       = popEn && !pushEn && r_empty;
        if (pushEn && popEn) begin
            w_write = 1'b1;
            if (r_empty) begin
                w_count_nxt = CNT_BITS'(1);
            end else begin
                w_shift = 1'b1;
                w_widx  = IDX_BITS'(r_count - 1'b1);
            end
        end else if (pushEn) begin
            if (!r_full) begin
                w_write     = 1'b1;
                w_widx      = IDX_BITS'(r_count);
                w_count_nxt = r_count + 1'b1;
            end
`ifdef ADDR_QUEUE_OVERWRITE_EN
            else begin
                w_shift = 1'b1;
                w_write = 1'b1;
                w_widx  = IDX_BITS'(REG_DEPTH - 1);
            end
`else
            else begin
                w_write = 1'b0;
            end
`endif
        end else if (popEn && !r_empty) begin
            w_shift     = 1'b1;
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < REG_DEPTH; i++) begin
            w_data_nxt[i] = r_data[i];
        end
        if (w_shift) begin
            for (int i = 0; i < REG_DEPTH - 1; i++) begin
                w_data_nxt[i] = r_data[i+1];
            end
        end
        for (int i = 0; i < REG_DEPTH; i++) begin
            if (w_write && (w_widx == IDX_BITS'(i))) begin
                w_data_nxt[i] = inVector;
            end
        end
        for (int i = 0; i < REG_DEPTH; i++) begin
            w_valid_nxt[i] = (CNT_BITS'(i) < w_count_nxt);
        end
    end

    // Flush leaves entry data in place; only the occupancy state is cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                r_data[i] <= '0;
            end
            r_count     <= '0;
            r_valid     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_count     <= '0;
            r_valid     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                r_data[i] <= w_data_nxt[i];
            end
            r_count     <= w_count_nxt;
            r_valid     <= w_valid_nxt;
            r_full      <= (w_count_nxt == DEPTH_C);
            r_empty     <= (w_count_nxt == '0);
            r_overflow  <= w_ovf;
            r_underflow <= w_unf;
        end
    end

    // Scan from the top down so the lowest matching index wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = REG_DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_data[i] == lookupAddr)) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_BITS'(i);
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < REG_DEPTH; g++) begin : g_pack
            assign dataVec[g*DATA_BITS +: DATA_BITS] = r_data[g];
        end
    endgenerate

    assign headData  = r_empty ? '0 : r_data[0];
    assign validVec  = r_valid;
    assign count     = r_count;
    assign full      = r_full;
    assign empty     = r_empty;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign lookupHit = w_hit;
    assign lookupIdx = w_hit_idx;

endmodule

// File: tb/tb_addr_shift_queue.sv
// Bench for addr_shift_queue: queue-based reference model checked every cycle plus directed literal checks.
module tb_addr_shift_queue;
    localparam int DW = 32;
    localparam int D  = 5;
    localparam int CB = 3;
    localparam int IB = 3;

    logic            clk;
    logic            reset;
    logic            flush;
    logic            pushEn;
    logic [DW-1:0]   inVector;
    logic            popEn;
    logic [DW-1:0]   lookupAddr;
    logic [DW-1:0]   headData;
    logic [DW*D-1:0] dataVec;
    logic [D-1:0]    validVec;
    logic [CB-1:0]   count;
    logic            full;
    logic            empty;
    logic            overflow;
    logic            underflow;
    logic            lookupHit;
    logic [IB-1:0]   lookupIdx;

    int checks = 0;
    int errors = 0;

    addr_shift_queue #(.DATA_BITS(DW), .REG_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .flush(flush), .pushEn(pushEn),
        .inVector(inVector), .popEn(popEn), .lookupAddr(lookupAddr),
        .headData(headData), .dataVec(dataVec), .validVec(validVec),
        .count(count), .full(full), .empty(empty), .overflow(overflow),
        .underflow(underflow), .lookupHit(lookupHit), .lookupIdx(lookupIdx)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: contents held as an ordered queue, head at index 0
    logic [DW-1:0] exp_q[$];
    logic          exp_ovf = 1'b0;
    logic          exp_unf = 1'b0;
    logic          live    = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
            live    = 1'b1;
        end else if (flush) begin
            exp_q.delete();
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            exp_ovf = pushEn && !popEn && (exp_q.size() == D);
            exp_unf = popEn && !pushEn && (exp_q.size() == 0);
            if (pushEn && popEn) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                exp_q.push_back(inVector);
            end else if (pushEn) begin
                if (exp_q.size() < D) begin
                    exp_q.push_back(inVector);
                end else begin
`ifdef ADDR_QUEUE_OVERWRITE_EN
                    void'(exp_q.pop_front());
                    exp_q.push_back(inVector);
`endif
                end
            end else if (popEn) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
    end

    // compare process
    always @(negedge clk) begin
        int            n;
        logic          m_hit;
        logic [63:0]   m_idx;
        if (live) begin
            n = exp_q.size();
            chk("count", 64'(count), 64'(n));
            chk("valid_vec", 64'(validVec), (64'd1 << n) - 64'd1);
            chk("full", 64'(full), 64'(n == D));
            chk("empty", 64'(empty), 64'(n == 0));
            chk("overflow", 64'(overflow), 64'(exp_ovf));
            chk("underflow", 64'(underflow), 64'(exp_unf));
            chk("head_data", 64'(headData), (n != 0) ? 64'(exp_q[0]) : 64'd0);
            for (int i = 0; i < n; i++) begin
                chk("entry", 64'(dataVec[i*DW +: DW]), 64'(exp_q[i]));
            end
            m_hit = 1'b0;
            m_idx = 64'd0;
            for (int i = 0; i < n; i++) begin
                if (!m_hit && exp_q[i] == lookupAddr) begin
                    m_hit = 1'b1;
                    m_idx = 64'(i);
                end
            end
            chk("lookup_hit", 64'(lookupHit), 64'(m_hit));
            chk("lookup_idx", 64'(lookupIdx), m_idx);
        end
    end

    // driver: hold inputs for one edge, then return to idle
    task automatic step(input logic pp, input logic [DW-1:0] dd, input logic po,
                        input logic fl, input logic rs);
        pushEn   = pp;
        inVector = dd;
        popEn    = po;
        flush    = fl;
        reset    = rs;
        @(posedge clk);
        #1;
        pushEn   = 1'b0;
        popEn    = 1'b0;
        flush    = 1'b0;
        reset    = 1'b0;
        inVector = '0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_valid"}, 64'(validVec), 64'd0);
        chk({tag, "_head"}, 64'(headData), 64'd0);
        chk({tag, "_full"}, 64'(full), 64'd0);
        chk({tag, "_empty"}, 64'(empty), 64'd1);
        chk({tag, "_ovf"}, 64'(overflow), 64'd0);
        chk({tag, "_unf"}, 64'(underflow), 64'd0);
        for (int i = 0; i < D; i++) begin
            chk({tag, "_data"}, 64'(dataVec[i*DW +: DW]), 64'd0);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; pushEn = 1'b0; popEn = 1'b0;
        inVector = '0; lookupAddr = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_reset_state("rst0");

        step(1, 32'h10, 0, 0, 0);
        step(1, 32'h20, 0, 0, 0);
        step(1, 32'h30, 0, 0, 0);
        chk("t1_count", 64'(count), 64'd3);
        chk("t1_valid", 64'(validVec), 64'h07);
        chk("t1_head", 64'(headData), 64'h10);
        chk("t1_empty", 64'(empty), 64'd0);

        step(1, 32'h40, 1, 0, 0);
        chk("t2_count", 64'(count), 64'd3);
        chk("t2_e0", 64'(dataVec[0 +: DW]), 64'h20);
        chk("t2_e1", 64'(dataVec[DW +: DW]), 64'h30);
        chk("t2_e2", 64'(dataVec[2*DW +: DW]), 64'h40);
        chk("t2_head", 64'(headData), 64'h20);
        lookupAddr = 32'h30;
        #1;
        chk("t2_hit", 64'(lookupHit), 64'd1);
        chk("t2_idx", 64'(lookupIdx), 64'd1);

        step(1, 32'h50, 0, 1, 0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        chk("flush_hit", 64'(lookupHit), 64'd0);

        for (int v = 1; v <= 5; v++) step(1, 32'(v), 0, 0, 0);
        chk("fill_full", 64'(full), 64'd1);
        step(1, 32'h6, 0, 0, 0);
        chk("ovf_pulse", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(count), 64'd5);
`ifdef ADDR_QUEUE_OVERWRITE_EN
        chk("ovf_head", 64'(headData), 64'h2);
        chk("ovf_tail", 64'(dataVec[4*DW +: DW]), 64'h6);
`else
        chk("ovf_head", 64'(headData), 64'h1);
        chk("ovf_tail", 64'(dataVec[4*DW +: DW]), 64'h5);
`endif
        step(0, 0, 0, 0, 0);
        chk("ovf_clear", 64'(overflow), 64'd0);
        step(1, 32'h7, 1, 0, 0);
        chk("full_pp_count", 64'(count), 64'd5);
        chk("full_pp_ovf", 64'(overflow), 64'd0);
        chk("full_pp_tail", 64'(dataVec[4*DW +: DW]), 64'h7);

        step(0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0);
        chk("unf_pulse", 64'(underflow), 64'd1);
        chk("unf_count", 64'(count), 64'd0);
        step(0, 0, 0, 0, 0);
        chk("unf_clear", 64'(underflow), 64'd0);
        step(1, 32'h7, 1, 0, 0);
        chk("empty_pp_count", 64'(count), 64'd1);
        chk("empty_pp_head", 64'(headData), 64'h7);
        chk("empty_pp_unf", 64'(underflow), 64'd0);

        step(0, 0, 0, 1, 0);
        step(1, 32'hA, 0, 0, 0);
        step(1, 32'hB, 0, 0, 0);
        step(1, 32'hA, 0, 0, 0);
        lookupAddr = 32'hA;
        #1;
        chk("lk_hit0", 64'(lookupHit), 64'd1);
        chk("lk_idx0", 64'(lookupIdx), 64'd0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("lk_hit1", 64'(lookupHit), 64'd1);
        chk("lk_idx1", 64'(lookupIdx), 64'd0);
        chk("lk_head1", 64'(headData), 64'hA);
        lookupAddr = 32'hC;
        #1;
        chk("lk_miss", 64'(lookupHit), 64'd0);
        step(0, 0, 1, 0, 0);
        chk("empty_head_zero", 64'(headData), 64'd0);

        for (int i = 0; i < 24; i++) begin
            lookupAddr = 32'(100 + (i % 7));
            step((i % 3) != 0, 32'(100 + (i % 7)), (i % 4) == 1, 0, 0);
        end

        step(1, 32'h99, 0, 0, 1);
        chk_reset_state("rst1");
        step(1, 32'h99, 0, 0, 0);
        chk("post_rst_push", 64'(headData), 64'h99);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
